// File: rtl/clk_ratio_detector.sv
// Measures a divided clock in the clk domain: period, high time, ratio.
// Declares lock on a stable ratio and flags mismatches and loss of signal.
module clk_ratio_detector #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 3,
    parameter int TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [2:0]       ratio,
    output logic             meas_valid,
    output logic             locked,
    output logic             err,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        TRACK
    } state_t;

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [MW-1:0]    LC  = MW'(LOCK_CNT);

    state_t           state;
    logic             prev_in;
    logic             armed;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [MW-1:0]    match_cnt;
    logic [MW-1:0]    match_nxt;
    logic             rise;
    logic             same;

    // A level that is already high out of reset is not an edge.
    assign rise      = div_in & ~prev_in & armed;
    assign same      = (cnt == period) && (hcnt == high_time);
    assign match_nxt = (match_cnt == LC) ? LC : match_cnt + MW'(1);

    function automatic logic [2:0] decode(
        input logic [CNT_W-1:0] p,
        input logic [CNT_W-1:0] h
    );
        logic [2:0] r;
        r = 3'd0;
        if ({h, 1'b0} == {1'b0, p}) begin
            case (p)
                CNT_W'(2):  r = 3'd1;
                CNT_W'(4):  r = 3'd2;
                CNT_W'(8):  r = 3'd3;
                CNT_W'(16): r = 3'd4;
                default:    r = 3'd0;
            endcase
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            prev_in    <= 1'b0;
            armed      <= 1'b0;
            cnt        <= '0;
            hcnt       <= '0;
            match_cnt  <= '0;
            period     <= '0;
            high_time  <= '0;
            ratio      <= 3'd0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            err        <= 1'b0;
            timeout    <= 1'b0;
            prev_in    <= div_in;
            if (!div_in) begin
                armed <= 1'b1;
            end

            if (rise) begin
                cnt  <= ONE;
                hcnt <= ONE;
            end else begin
                if (cnt != TO) begin
                    cnt <= cnt + ONE;
                end
                if (div_in && hcnt != TO) begin
                    hcnt <= hcnt + ONE;
                end
            end

            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state <= ACQ;
                    end
                end
                ACQ, TRACK: begin
                    if (rise) begin
                        period     <= cnt;
                        high_time  <= hcnt;
                        ratio      <= decode(cnt, hcnt);
                        meas_valid <= 1'b1;
                        state      <= TRACK;
                        if (state == ACQ) begin
                            match_cnt <= '0;
                        end else if (same) begin
                            match_cnt <= match_nxt;
                            if (match_nxt == LC) begin
                                locked <= 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                            locked    <= 1'b0;
                            err       <= locked;
                        end
                    end else if (cnt == TO) begin
                        timeout   <= 1'b1;
                        state     <= IDLE;
                        locked    <= 1'b0;
                        ratio     <= 3'd0;
                        period    <= '0;
                        high_time <= '0;
                        match_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_ratio_detector.sv
// Randomized bench for clk_ratio_detector with a queue scoreboard.
// A behavioural model predicts every pulse cycle and its output values.
module tb_clk_ratio_detector;

    localparam int CNT_W    = 8;
    localparam int LOCK_CNT = 3;
    localparam int TIMEOUT  = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             div_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [2:0]       ratio;
    logic             meas_valid;
    logic             locked;
    logic             err;
    logic             timeout;

    clk_ratio_detector #(
        .CNT_W(CNT_W),
        .LOCK_CNT(LOCK_CNT),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .div_in(div_in),
        .period(period),
        .high_time(high_time),
        .ratio(ratio),
        .meas_valid(meas_valid),
        .locked(locked),
        .err(err),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit mv;
        bit er;
        bit to;
        int p;
        int h;
        int r;
        bit lk;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  checks = 0;
    int  passes = 0;

    always @(posedge clk) cyc++;

    // Reference model state: counts since the last rising edge.
    bit m_prev_low;
    int m_len, m_ones, m_phase, m_lp, m_lh, m_match;
    bit m_lock;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at cyc %0d",
                      name, act, exp, cyc);
    endtask

    function automatic int exp_ratio(int p, int h);
        if (2 * h == p && p inside {2, 4, 8, 16}) return $clog2(p);
        return 0;
    endfunction

    task automatic model_reset();
        m_prev_low = 0;
        m_len = 0; m_ones = 0; m_phase = 0;
        m_lp = 0; m_lh = 0; m_match = 0; m_lock = 0;
    endtask

    // Predicts the effect of sample v at the coming posedge.
    task automatic model_step(bit v);
        ev_t e;
        bit  rise;
        rise = v && m_prev_low;
        e = '{cyc + 1, 0, 0, 0, 0, 0, 0, 0};
        if (rise) begin
            if (m_phase == 0) begin
                m_phase = 1;
            end else begin
                e.mv = 1;
                e.p = m_len;
                e.h = m_ones;
                if (m_phase == 1) begin
                    m_match = 0;
                end else if (m_len == m_lp && m_ones == m_lh) begin
                    if (m_match < LOCK_CNT) m_match++;
                    if (m_match == LOCK_CNT) m_lock = 1;
                end else begin
                    e.er = m_lock;
                    m_match = 0;
                    m_lock = 0;
                end
                m_phase = 2;
                m_lp = e.p;
                m_lh = e.h;
                e.r = exp_ratio(e.p, e.h);
                e.lk = m_lock;
                sb.push_back(e);
            end
            m_len = 1;
            m_ones = 1;
        end else begin
            if (m_phase != 0 && m_len >= TIMEOUT) begin
                e.to = 1;
                m_phase = 0; m_lock = 0; m_match = 0;
                m_lp = 0; m_lh = 0;
                sb.push_back(e);
            end
            if (m_len < TIMEOUT) m_len++;
            if (v && m_ones < TIMEOUT) m_ones++;
        end
        m_prev_low = !v;
    endtask

    task automatic drive(bit v);
        @(negedge clk);
        div_in = v;
        model_step(v);
    endtask

    task automatic run(int p, int h, int n);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < p; i++) drive(i < h);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_period"}, int'(period), 0);
        check({tag, "_high"}, int'(high_time), 0);
        check({tag, "_ratio"}, int'(ratio), 0);
        check({tag, "_mv"}, int'(meas_valid), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_timeout"}, int'(timeout), 0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        check("pre_reset_locked", int'(locked), int'(m_lock));
        rst = 1'b0;
        #1;
        check_zero("async");
        sb.delete();
        model_reset();
        div_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: pops an expectation whenever the DUT presents a pulse.
    always @(negedge clk) begin
        if (rst && (meas_valid || err || timeout)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("meas_valid", int'(meas_valid), int'(e.mv));
                check("err", int'(err), int'(e.er));
                check("timeout", int'(timeout), int'(e.to));
                check("period", int'(period), e.p);
                check("high_time", int'(high_time), e.h);
                check("ratio", int'(ratio), e.r);
                check("locked", int'(locked), int'(e.lk));
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        div_in = 1'b0;
        model_reset();
        #7;
        check_zero("reset");
        #3;
        rst = 1'b1;

        repeat ($urandom_range(1, 5)) drive(0);
        run(4, 2, 8);
        run(2, 1, 6);
        run(8, 4, 6);
        run(16, 8, 6);
        run(8, 4, 6);
        run(4, 2, 6);
        run(6, 3, 6);
        run(4, 1, 6);
        for (int s = 0; s < 20; s++) begin
            int p, h;
            p = $urandom_range(2, 20);
            h = $urandom_range(1, p - 1);
            run(p, h, $urandom_range(1, 6));
        end

        run(2, 1, 6);
        repeat (300) drive(0);
        run(2, 1, 6);

        run(4, 2, 6);
        async_reset();
        repeat (300) drive(1);
        drive(0);
        run(4, 2, 6);
        repeat (4) drive(0);

        @(negedge clk);
        #1;
        check("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/clk_ratio_detector.md
Name: clk_ratio_detector

Overview:
- Receive-side counterpart to the clock divider: measures a divided clock generated in the `clk` domain and reports its period, high time and divide ratio.
- Declares lock once the measured ratio is stable.
- Used in the divider bench and in SoC clock-health monitoring to confirm that `divideby2/4/8/16` are alive and correct.
- `div_in` must be a registered signal synchronous to `clk`. No synchroniser is included.

Parameters:
- CNT_W, 8, width of the period/high-time counters.
- LOCK_CNT, 3, number of consecutive matching periods after the first capture required for lock.
- TIMEOUT, 255, cycles without a rising edge before declaring loss of signal. Must be ≤ 2^CNT_W−1 and > 16.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- div_in  input  1  divided clock under measurement, synchronous to clk.
- period  output  CNT_W  last measured period, in clk cycles.
- high_time  output  CNT_W  clk cycles div_in was high in the last period.
- ratio  output  3  0 = unsupported/none, 1 = /2, 2 = /4, 3 = /8, 4 = /16.
- meas_valid  output  1  one-cycle pulse for each new capture.
- locked  output  1  stable ratio detected.
- err  output  1  one-cycle pulse on a period/high mismatch while locked.
- timeout  output  1  one-cycle pulse on loss of signal.

Behaviour:
- **Reset** (rst=0, async): all outputs, counters and internal registers are 0. State is IDLE. prev_in = 0.
- **Edge detect:** prev_in <= div_in every cycle. rise = div_in & ~prev_in. Level high during/after reset is not an edge; a 0→1 transition is required.
- **Counters:**
  - On rise: cnt <= 1, hcnt <= 1.
  - Otherwise: cnt <= cnt+1, saturating at TIMEOUT; hcnt <= hcnt + div_in.
  - Captured values at rise are cnt and hcnt. Example, /2 waveform: period=2, high_time=1.
- **States:**
  - IDLE: on rise → ACQ. No capture.
  - ACQ: on rise → capture, go TRACK, meas_valid=1, match_cnt=0.
  - TRACK: on rise → capture, meas_valid=1.
    - If (cnt,hcnt) equals the previous capture: match_cnt++, saturating at LOCK_CNT.
    - Else: match_cnt <= 0, locked <= 0, and err=1 if locked was 1.
    - locked <= 1 when match_cnt reaches LOCK_CNT. This happens on the (LOCK_CNT+1)-th TRACK capture, counting the ACQ capture as the first.
  - ACQ or TRACK, no rise, cnt == TIMEOUT: timeout=1; go IDLE; locked, ratio, period, high_time, match_cnt <= 0.
- **Ratio decode:** registered with the capture. ratio is nonzero only if period ∈ {2,4,8,16} and 2·high_time == period; otherwise 0. period and high_time are still reported when ratio is 0.
- **Output timing:** all outputs are registered. Updates occur at the clk edge that samples rise, so they are visible one cycle after div_in goes high. Pulse outputs last exactly one clk.
- **Holding:** period/high_time/ratio hold between captures.
- **Simultaneous events:** rise in the cycle cnt == TIMEOUT → rise wins; normal capture, no timeout.
- **Timeout pulse:** fires once per loss event, since the state leaves ACQ/TRACK. Re-acquisition needs two fresh rises.
- **Reset mid-operation:** immediate clear. An edge in flight is not counted.
- **Width:** counters never wrap, because saturation at TIMEOUT keeps them within CNT_W.

Test Plan:
- **/4 lock:** rst low 10 ns then high; drive div_in from divider `divideby4` → first meas_valid with period=4, high_time=2, ratio=2; locked=1 at the 4th capture; err never pulses.
- **All ratios:** repeat for /2, /8, /16 → (period, high_time, ratio) = (2,1,1), (8,4,3), (16,8,4); locked after 4 captures each.
- **Ratio change while locked:** locked on /8, switch div_in to /4 mid-run → one err pulse and locked=0 at the first /4 capture (period=4, ratio=2); re-lock 3 captures later.
- **Unsupported ratio:** period 6, high 3 (/6) and period 4, high 1 (25% duty) → ratio=0, period/high_time reported correctly, locked still asserts.
- **Loss of signal:** locked on /2, hold div_in=0 → timeout pulse exactly 255 cycles after the last rise; locked/ratio/period = 0; restart div_in → no meas_valid on first rise, capture on second.
- **Async reset:** assert rst mid-period while locked, off clock edge → outputs clear immediately without waiting for clk; after release, a constant-high div_in produces no capture.
